// File: rtl/dmem_pkg.sv
// Shared types and sizes for the block data memory: FSM states, the latched
// request record and the array geometry.
package dmem_pkg;

  localparam int BLOCK_W = 32;
  localparam int ADDR_W  = 6;
  localparam int DEPTH   = 64;
  localparam int CNT_W   = 4;   // holds LATENCY-1 for LATENCY up to 15
  localparam int ACC_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

  typedef struct packed {
    op_t               op;
    logic [ADDR_W-1:0] addr;
    logic [BLOCK_W-1:0] data;
  } req_t;

  function automatic logic [ACC_W-1:0] sat_inc(input logic [ACC_W-1:0] v);
    return (v == {ACC_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// 64 x 32 block storage: synchronous write, enabled registered read port,
// asynchronous clear of every block and of the read register.
module dmem_array
  import dmem_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               we,
  input  logic               re,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [BLOCK_W-1:0] wdata,
  output logic [BLOCK_W-1:0] rdata
);

  logic [BLOCK_W-1:0] mem [DEPTH];

  // NOTE: the storage is reset on purpose so every block reads back zero after
  // reset; this keeps it out of block RAM, which cannot be cleared in one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/block_data_memory.sv
// Multi-cycle block data memory with IDLE/BUSY/DONE handshake. Defining
// DMEM_ACCESS_COUNT_EN adds saturating read_count/write_count outputs.
module block_data_memory
  import dmem_pkg::*;
#(
  parameter int LATENCY = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [ADDR_W-1:0]  mem_address,
  input  logic [BLOCK_W-1:0] mem_writedata,
  output logic [BLOCK_W-1:0] mem_readdata,
  output logic               mem_busywait
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [ACC_W-1:0]   read_count,
  output logic [ACC_W-1:0]   write_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  req_t              req_q;
  logic              request;
  logic              access;
  logic              arr_we, arr_re;

  assign request = mem_read | mem_write;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the simulator runs blocks.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && request) begin
        // A simultaneous read and write is treated as a write only.
        req_q.op   <= mem_write ? OP_WRITE : OP_READ;
        req_q.addr <= mem_address;
        req_q.data <= mem_writedata;
        cnt_q      <= CNT_INIT;
      end else if (state_q == BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    mem_busywait = 1'b0;
    access       = 1'b0;
    unique case (state_q)
      IDLE: begin
        mem_busywait = request;
        if (request) state_d = BUSY;
      end
      BUSY: begin
        mem_busywait = 1'b1;
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign arr_we = access && (req_q.op == OP_WRITE);
  assign arr_re = access && (req_q.op == OP_READ);

  dmem_array u_array (
    .clock (clock),
    .reset (reset),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (req_q.addr),
    .wdata (req_q.data),
    .rdata (mem_readdata)
  );

`ifdef DMEM_ACCESS_COUNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_count  <= '0;
      write_count <= '0;
    end else begin
      if (arr_re) read_count  <= sat_inc(read_count);
      if (arr_we) write_count <= sat_inc(write_count);
    end
  end
`endif

endmodule

// File: tb/tb_block_data_memory.sv
// Directed bench for block_data_memory (LATENCY=5): handshake timing, data
// path, request hold/change during an access, and reset mid-access.
module tb_block_data_memory;
  import dmem_pkg::*;

  localparam int LAT = 5;

  logic               clock = 1'b0;
  logic               reset;
  logic               mem_read;
  logic               mem_write;
  logic [ADDR_W-1:0]  mem_address;
  logic [BLOCK_W-1:0] mem_writedata;
  logic [BLOCK_W-1:0] mem_readdata;
  logic               mem_busywait;
`ifdef DMEM_ACCESS_COUNT_EN
  logic [ACC_W-1:0]   read_count;
  logic [ACC_W-1:0]   write_count;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int edges;

  block_data_memory #(.LATENCY(LAT)) dut (
    .clock         (clock),
    .reset         (reset),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    .read_count    (read_count),
    .write_count   (write_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts just after a rising edge; returns the number of edges at which
  // busywait was high, and ends just after the DONE->IDLE edge.
  task automatic access(input logic rd, input logic wr,
                        input logic [ADDR_W-1:0] a, input logic [BLOCK_W-1:0] d,
                        input logic [ADDR_W-1:0] alt_a, input logic [BLOCK_W-1:0] alt_d,
                        input bit hold, output int n);
    mem_read      = rd;
    mem_write     = wr;
    mem_address   = a;
    mem_writedata = d;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!mem_busywait) break;
      n++;
      @(posedge clock); #1;
      mem_address   = alt_a;
      mem_writedata = alt_d;
      if (!hold) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    end
    @(posedge clock); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_address = '0; mem_writedata = '0;
    #12;
    check("reset_readdata", mem_readdata, 32'h0);
    check("reset_busy", {31'b0, mem_busywait}, 32'h0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Read from a cleared block.
    access(1'b1, 1'b0, 6'h05, 32'h0, 6'h05, 32'h0, 1'b0, edges);
    check("rd05_edges", edges, LAT + 1);
    check("rd05_data", mem_readdata, 32'h0);

    // Write then an immediate read of the same block.
    access(1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, 6'h2A, 32'hDEADBEEF, 1'b0, edges);
    check("wr2A_edges", edges, LAT + 1);
    check("wr2A_rdata_kept", mem_readdata, 32'h0);
    access(1'b1, 1'b0, 6'h2A, 32'h0, 6'h2A, 32'h0, 1'b0, edges);
    check("rd2A_edges", edges, LAT + 1);
    check("rd2A_data", mem_readdata, 32'hDEADBEEF);

    // Read held through DONE must be accepted only once.
    access(1'b1, 1'b0, 6'h2A, 32'h0, 6'h2A, 32'h0, 1'b1, edges);
    check("hold_edges", edges, LAT + 1);
    check("hold_data", mem_readdata, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("hold_no_reaccept", {31'b0, mem_busywait}, 32'h0);
    end
    @(posedge clock); #1;

    // Address and data change during BUSY must not redirect the write.
    access(1'b0, 1'b1, 6'h01, 32'hA5A50001, 6'h3F, 32'hFFFFFFFF, 1'b0, edges);
    check("wr01_edges", edges, LAT + 1);
`ifdef DMEM_ACCESS_COUNT_EN
    check("cnt_reads_3", {16'b0, read_count}, 32'd3);
    check("cnt_writes_2", {16'b0, write_count}, 32'd2);
`endif
    access(1'b1, 1'b0, 6'h3F, 32'h0, 6'h3F, 32'h0, 1'b0, edges);
    check("rd3F_data", mem_readdata, 32'h0);
    access(1'b1, 1'b0, 6'h01, 32'h0, 6'h01, 32'h0, 1'b0, edges);
    check("rd01_data", mem_readdata, 32'hA5A50001);

    // Read and write together: write only, readdata untouched.
    access(1'b1, 1'b1, 6'h20, 32'h0BADF00D, 6'h20, 32'h0BADF00D, 1'b0, edges);
    check("both_edges", edges, LAT + 1);
    check("both_rdata_kept", mem_readdata, 32'hA5A50001);
    access(1'b1, 1'b0, 6'h20, 32'h0, 6'h20, 32'h0, 1'b0, edges);
    check("rd20_data", mem_readdata, 32'h0BADF00D);
`ifdef DMEM_ACCESS_COUNT_EN
    check("cnt_reads_6", {16'b0, read_count}, 32'd6);
    check("cnt_writes_3", {16'b0, write_count}, 32'd3);
`endif

    // Reset during BUSY of a write discards it and clears everything.
    mem_write = 1'b1; mem_address = 6'h10; mem_writedata = 32'h12345678;
    @(posedge clock); #1;
    mem_write = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("rst_mid_busy", {31'b0, mem_busywait}, 32'h0);
    check("rst_mid_readdata", mem_readdata, 32'h0);
`ifdef DMEM_ACCESS_COUNT_EN
    check("rst_mid_reads", {16'b0, read_count}, 32'd0);
    check("rst_mid_writes", {16'b0, write_count}, 32'd0);
`endif
    #2;
    reset = 1'b1;
    @(posedge clock); #1;
    access(1'b1, 1'b0, 6'h10, 32'h0, 6'h10, 32'h0, 1'b0, edges);
    check("rd10_edges", edges, LAT + 1);
    check("rd10_data", mem_readdata, 32'h0);
    access(1'b1, 1'b0, 6'h01, 32'h0, 6'h01, 32'h0, 1'b0, edges);
    check("rd01_cleared", mem_readdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
